// File: rtl/ws2812_multi_driver.sv
// ws2812_multi_driver: multi-channel WS2812-style strip driver.
// A byte-addressable frame buffer holds {G,R,B} per LED for every strip.
// All strips are serialised in parallel and stay bit-synchronous.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | outputs low, buffer writable, waiting for start
// S_HIGH  | high phase of a bit; 0-bits drop low after T0H cycles
// S_LOW   | low remainder of the bit, until the bit totals TBIT cycles
// S_LATCH | strip latch gap of TRESET low cycles, then done pulse
module ws2812_multi_driver #(
    parameter int CHANNELS    = 2,
    parameter int LEDS_PER_CH = 64,
    parameter int T0H         = 20,
    parameter int T1H         = 40,
    parameter int TBIT        = 63,
    parameter int TRESET      = 2500,
    parameter int ADDR_W      = $clog2(CHANNELS*LEDS_PER_CH*3),
    parameter int CNT_W       = $clog2(LEDS_PER_CH+1)
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [7:0]          wr_data,
    input  logic                start,
    input  logic [CNT_W-1:0]    led_count,
    output logic                busy,
    output logic                done,
    output logic                wr_err,
    output logic [CHANNELS-1:0] led_dout
);

    localparam int DEPTH = CHANNELS*LEDS_PER_CH*3;
    // One counter serves bit phases and the latch gap, so size it for the larger.
    localparam int CW = $clog2(TRESET + TBIT + 1);
    localparam logic [CNT_W-1:0] LEDS_MAX = CNT_W'(LEDS_PER_CH);
    localparam logic [ADDR_W:0]  DEPTH_W  = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_LATCH} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [4:0]        bit_q, bit_d;
    logic [CNT_W-1:0]  led_q, led_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [23:0]       sr_q [CHANNELS];
    logic [23:0]       sr_d [CHANNELS];
    logic              done_q, done_d;
    logic              wr_err_q;

    logic [7:0]        mem_q [DEPTH];
    logic              wr_ok;
    logic [CNT_W-1:0]  n_clamped;
    logic [CNT_W-1:0]  led_sel;
    logic [23:0]       ld_word [CHANNELS];

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign wr_err = wr_err_q;
    assign wr_ok  = wr_en && !busy && ({1'b0, wr_addr} < DEPTH_W);
    assign n_clamped = (led_count > LEDS_MAX) ? LEDS_MAX : led_count;

    // Frame buffer: plain registers without reset, writable only while idle.
    always_ff @(posedge clk_clk) begin
        if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Next LED word per channel; a write in the start cycle is forwarded so it
    // lands in the frame even though the buffer only updates on that edge.
    always_comb begin
        logic [ADDR_W-1:0] addr;
        addr    = '0;
        led_sel = (state_q == S_IDLE) ? '0 : led_q + 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
            ld_word[c] = '0;
            for (int k = 0; k < 3; k++) begin
                addr = ADDR_W'((c*LEDS_PER_CH + int'(led_sel))*3 + k);
                ld_word[c][8*(2-k) +: 8] = (wr_ok && (wr_addr == addr)) ? wr_data : mem_q[addr];
            end
        end
    end

    // State and datapath registers; reset abandons any frame immediately.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            led_q    <= '0;
            n_q      <= '0;
            sr_q     <= '{default: '0};
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            led_q    <= led_d;
            n_q      <= n_d;
            sr_q     <= sr_d;
            done_q   <= done_d;
            wr_err_q <= wr_en && !wr_ok;
        end
    end

    // Next-state and serial outputs; bit_q counts remaining bits of the LED.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        led_d    = led_q;
        n_d      = n_q;
        sr_d     = sr_q;
        done_d   = 1'b0;
        led_dout = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d   = n_clamped;
                    led_d = '0;
                    bit_d = 5'd23;
                    if (n_clamped == '0) begin
                        state_d = S_LATCH;
                        cnt_d   = CW'(TRESET-1);
                    end else begin
                        sr_d    = ld_word;
                        state_d = S_HIGH;
                        cnt_d   = CW'(T1H-1);
                    end
                end
            end
            S_HIGH: begin
                for (int c = 0; c < CHANNELS; c++) begin
                    led_dout[c] = sr_q[c][23] || (cnt_q >= CW'(T1H-T0H));
                end
                if (cnt_q == '0) begin
                    state_d = S_LOW;
                    cnt_d   = CW'(TBIT-T1H-1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_LOW: begin
                if (cnt_q == '0) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        sr_d[c] = {sr_q[c][22:0], 1'b0};
                    end
                    if (bit_q == '0) begin
                        if (led_q == n_q - 1'b1) begin
                            state_d = S_LATCH;
                            cnt_d   = CW'(TRESET-1);
                        end else begin
                            led_d   = led_q + 1'b1;
                            bit_d   = 5'd23;
                            sr_d    = ld_word;
                            state_d = S_HIGH;
                            cnt_d   = CW'(T1H-1);
                        end
                    end else begin
                        bit_d   = bit_q - 1'b1;
                        state_d = S_HIGH;
                        cnt_d   = CW'(T1H-1);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_LATCH: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ws2812_multi_driver.sv
// Directed bench for ws2812_multi_driver with short bit timing.
module tb_ws2812_multi_driver;

    logic       clk_clk = 1'b0;
    logic       reset_reset;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic [2:0] led_count;
    logic       busy, done, wr_err;
    logic [1:0] led_dout;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_mem [24];
    logic [1:0] wave [700];
    int         hi_len [2][96];

    ws2812_multi_driver #(
        .CHANNELS(2), .LEDS_PER_CH(4), .T0H(2), .T1H(4), .TBIT(6), .TRESET(10)
    ) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .led_count(led_count),
        .busy(busy), .done(done), .wr_err(wr_err), .led_dout(led_dout)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Single buffer write; out-of-range addresses leave the model untouched.
    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk_clk);
        wr_en = 1'b0;
        if (a < 5'd24) begin
            exp_mem[a] = d;
            chk("wr_err_good", wr_err, 0);
        end else begin
            chk("wr_err_range", wr_err, 1);
            @(negedge clk_clk);
            chk("wr_err_clear", wr_err, 0);
        end
    endtask

    // mode 0: plain frame; 1: write+start poked mid-frame; 2: reset in bit 10.
    task automatic frame(input logic [2:0] cnt, input int exp_n, input int exp_busy,
                         input int mode, input logic do_wr,
                         input logic [4:0] wa, input logic [7:0] wd);
        int cyc;
        int highs;
        int idx;
        logic [7:0] byt;
        logic [5:0] pat, exp_pat;
        start = 1'b1; led_count = cnt;
        if (do_wr) begin
            wr_en = 1'b1; wr_addr = wa; wr_data = wd; exp_mem[wa] = wd;
        end
        @(negedge clk_clk);
        start = 1'b0; wr_en = 1'b0;
        chk("busy_rise", busy, 1);
        cyc = 0;
        while (busy === 1'b1 && cyc < 700) begin
            wave[cyc] = led_dout;
            if (mode == 1 && cyc == 40) begin
                wr_en = 1'b1; wr_addr = 5'd0; wr_data = ~exp_mem[0];
                start = 1'b1; led_count = 3'd4;
            end
            if (mode == 1 && cyc == 41) begin
                wr_en = 1'b0; start = 1'b0;
                chk("wr_err_busy", wr_err, 1);
            end
            if (mode == 1 && cyc == 42) chk("wr_err_busy_clear", wr_err, 0);
            if (mode == 2 && cyc == 61) begin
                chk("pre_reset_dout", led_dout, 2'b11);
                reset_reset = 1'b1;
                #1;
                chk("reset_dout", led_dout, 0);
                chk("reset_busy", busy, 0);
                chk("reset_done", done, 0);
                @(negedge clk_clk);
                reset_reset = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk_clk);
                    chk("no_done_after_reset", done, 0);
                    chk("idle_after_reset", busy, 0);
                end
                return;
            end
            cyc++;
            @(negedge clk_clk);
        end
        chk("busy_len", cyc, exp_busy);
        chk("done_pulse", done, 1);
        for (int led = 0; led < exp_n; led++) begin
            for (int b = 0; b < 24; b++) begin
                idx = led*24 + b;
                for (int ch = 0; ch < 2; ch++) begin
                    byt = exp_mem[(ch*4 + led)*3 + b/8];
                    exp_pat = byt[7 - b%8] ? 6'b001111 : 6'b000011;
                    hi_len[ch][idx] = 0;
                    for (int t = 0; t < 6; t++) begin
                        pat[t] = wave[idx*6 + t][ch];
                        if (pat[t]) hi_len[ch][idx]++;
                    end
                    chk($sformatf("bit_ch%0d_led%0d_b%0d", ch, led, b), pat, exp_pat);
                end
            end
        end
        highs = 0;
        for (int t = exp_n*144; t < cyc; t++) begin
            if (wave[t] != 2'b00) highs++;
        end
        chk("latch_low", highs, 0);
        @(negedge clk_clk);
        chk("done_clear", done, 0);
    endtask

    initial begin
        reset_reset = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; led_count = '0;
        repeat (3) @(negedge clk_clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_dout", led_dout, 0);
        reset_reset = 1'b0;
        @(negedge clk_clk);

        // One LED per strip: ch0 = G80 R00 B01, ch1 all zero.
        wr(5'd0, 8'h80); wr(5'd1, 8'h00); wr(5'd2, 8'h01);
        wr(5'd12, 8'h00); wr(5'd13, 8'h00); wr(5'd14, 8'h00);
        frame(3'd1, 1, 154, 0, 1'b0, 5'd0, 8'h00);
        chk("ch0_bit0_hi", hi_len[0][0], 4);
        chk("ch0_bit1_hi", hi_len[0][1], 2);
        chk("ch0_bit22_hi", hi_len[0][22], 2);
        chk("ch0_bit23_hi", hi_len[0][23], 4);
        chk("ch1_bit0_hi", hi_len[1][0], 2);
        chk("ch1_bit23_hi", hi_len[1][23], 2);

        // Distinct bytes across the whole buffer, full-length frame.
        for (int a = 0; a < 24; a++) wr(5'(a), 8'(a*29 + 53));
        frame(3'd4, 4, 586, 0, 1'b0, 5'd0, 8'h00);

        // Empty frame and clamped count.
        frame(3'd0, 0, 10, 0, 1'b0, 5'd0, 8'h00);
        frame(3'd7, 4, 586, 0, 1'b0, 5'd0, 8'h00);

        // Rejected writes: out of range while idle, and any write while busy.
        wr(5'd24, 8'hA5);
        frame(3'd4, 4, 586, 1, 1'b0, 5'd0, 8'h00);
        frame(3'd4, 4, 586, 0, 1'b0, 5'd0, 8'h00);

        // Reset in bit 10, then a fresh frame from LED0 bit 0.
        frame(3'd1, 1, 154, 2, 1'b0, 5'd0, 8'h00);
        frame(3'd4, 4, 586, 0, 1'b0, 5'd0, 8'h00);

        // Write committed in the start cycle is part of the frame.
        frame(3'd1, 1, 154, 0, 1'b1, 5'd0, 8'hFF);
        for (int b = 0; b < 8; b++) chk($sformatf("fwd_bit%0d_hi", b), hi_len[0][b], 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
